dac_sample_scheduler: RTL



---
 rtl/dac_sample_scheduler.sv | 107 ++++++++++
 1 files changed

// File: rtl/dac_sample_scheduler.sv
// DAC sample strobe generator: programmable-rate one-cycle strobe, suppressed
// for a settle window after every IAGC status change, with an issued-strobe counter.
module dac_sample_scheduler #(
  parameter int unsigned IAGC_STATUS_SIZE = 4,
  parameter int unsigned DIVIDER_SIZE     = 16,
  parameter int unsigned SETTLE_SIZE      = 8,
  parameter int unsigned COUNT_SIZE       = 16
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic [DIVIDER_SIZE-1:0]     i_divider,
  input  logic [SETTLE_SIZE-1:0]      i_settle_cycles,
  input  logic [IAGC_STATUS_SIZE-1:0] i_iagc_status,
  output logic                        o_sample,
  output logic                        o_settling,
  output logic [COUNT_SIZE-1:0]       o_sample_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t                      state, state_d;
  logic [DIVIDER_SIZE-1:0]     div_cnt, div_cnt_d;
  logic [SETTLE_SIZE-1:0]      settle_cnt, settle_cnt_d;
  logic [IAGC_STATUS_SIZE-1:0] prev_status;
  logic [COUNT_SIZE-1:0]       count_d;
  logic                        sample_d;
  logic                        status_change;

  assign status_change = (i_iagc_status != prev_status);

  // State, counters and registered outputs
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      div_cnt        <= '0;
      settle_cnt     <= '0;
      prev_status    <= '0;
      o_sample       <= 1'b0;
      o_settling     <= 1'b0;
      o_sample_count <= '0;
    end else begin
      state          <= state_d;
      div_cnt        <= div_cnt_d;
      settle_cnt     <= settle_cnt_d;
      prev_status    <= i_iagc_status;
      o_sample       <= sample_d;
      o_settling     <= (state_d == SETTLE);
      o_sample_count <= count_d;
    end
  end

  // Next-state logic; disable wins, then a status change beats a divider match
  always_comb begin
    state_d      = state;
    div_cnt_d    = div_cnt;
    settle_cnt_d = settle_cnt;
    count_d      = o_sample_count;
    sample_d     = 1'b0;

    if (!i_enable) begin
      state_d      = IDLE;
      div_cnt_d    = '0;
      settle_cnt_d = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_d   = RUN;
          div_cnt_d = '0;
        end
        RUN: begin
          if (status_change) begin
            state_d      = SETTLE;
            settle_cnt_d = i_settle_cycles;
            div_cnt_d    = '0;
          end else if (div_cnt == i_divider) begin
            sample_d  = 1'b1;
            div_cnt_d = '0;
            count_d   = o_sample_count + COUNT_SIZE'(1);
          end else begin
            div_cnt_d = div_cnt + DIVIDER_SIZE'(1);
          end
        end
        SETTLE: begin
          if (status_change) begin
            settle_cnt_d = i_settle_cycles;
          end else if (settle_cnt == '0) begin
            state_d   = RUN;
            div_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt - SETTLE_SIZE'(1);
          end
        end
        default: begin
          state_d      = IDLE;
          div_cnt_d    = '0;
          settle_cnt_d = '0;
        end
      endcase
    end
  end

endmodule
